wavegen_frame_decoder: RTL and testbench

Receives the MCU's byte-serial synth-control stream and turns each complete, checksum-valid frame into one wavegen record (frequency, velocity, shape, commands, eight envelope stages) for one oscillator channel. It sits between the byte transport (SPI/UART receiver) and the channel register bank that feeds the oscillators. It is the producer side of the wavegen record the oscillators consume.

---
 rtl/wavegen_frame_decoder_if.sv | 27 ++
 rtl/wavegen_frame_decoder.sv | 148 ++++++++++++++
 tb/tb_wavegen_frame_decoder.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wavegen_frame_decoder_if.sv
// Byte-stream input and wavegen record output of the frame decoder.
// The decoder connects through the master modport; the byte source and the record consumer use slave.
interface wavegen_frame_decoder_if #(
  parameter int N_CHANNELS = 16
);
  localparam int CH_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [375:0]          wg_data;
  logic [CH_W-1:0]       wg_channel;
  logic                  wg_valid;
  logic                  wg_ready;
  logic [N_CHANNELS-1:0] env_reset;
  logic                  frame_err;

  modport master (
    input  in_data, in_valid, wg_ready,
    output in_ready, wg_data, wg_channel, wg_valid, env_reset, frame_err
  );

  modport slave (
    output in_data, in_valid, wg_ready,
    input  in_ready, wg_data, wg_channel, wg_valid, env_reset, frame_err
  );
endinterface

// File: rtl/wavegen_frame_decoder.sv
// Decodes 50-byte synth-control frames (sync, channel, 47 payload bytes, XOR checksum)
// into one wavegen record per checksum-valid frame.
module wavegen_frame_decoder #(
  parameter int N_CHANNELS         = 16,
  parameter int TIMEOUT            = 4096,
  parameter int ENVELOPE_RESET_BIT = 0
) (
  input  logic                    clk,
  input  logic                    rstn,
  wavegen_frame_decoder_if.master bus
);
  localparam int               CH_W         = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int               TMO_W        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int               REC_W        = 376;
  localparam int               CMDS_LSB     = REC_W - 56;
  localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(TIMEOUT - 1);
  localparam logic [5:0]       LAST_PAYLOAD = 6'd46;
  localparam logic [7:0]       SYNC         = 8'hA5;

  typedef enum logic [2:0] {
    S_HUNT,
    S_CHAN,
    S_PAYLOAD,
    S_CHECK,
    S_OUTPUT
  } state_e;

  state_e                  state_q,      state_d;
  logic [5:0]              byte_cnt_q,   byte_cnt_d;
  logic [TMO_W-1:0]        tmo_q,        tmo_d;
  logic [7:0]              xor_q,        xor_d;
  logic [REC_W-1:0]        shadow_q,     shadow_d;
  logic [CH_W-1:0]         chan_q,       chan_d;
  logic [REC_W-1:0]        wg_data_q,    wg_data_d;
  logic [CH_W-1:0]         wg_channel_q, wg_channel_d;
  logic [N_CHANNELS-1:0]   env_reset_q,  env_reset_d;
  logic                    frame_err_q,  frame_err_d;

  logic accept;
  logic in_frame;

  assign accept   = bus.in_valid && (state_q != S_OUTPUT);
  assign in_frame = (state_q == S_CHAN) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);

  // NOTE: every variable gets its default before any branch; a path that leaves one unassigned infers a latch.
  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    tmo_d        = '0;
    xor_d        = xor_q;
    shadow_d     = shadow_q;
    chan_d       = chan_q;
    wg_data_d    = wg_data_q;
    wg_channel_d = wg_channel_q;
    env_reset_d  = '0;
    frame_err_d  = 1'b0;

    // Idle-gap watchdog; an accepted byte in the same cycle always wins.
    if (in_frame && !accept) begin
      if (tmo_q == TMO_LAST) begin
        frame_err_d = 1'b1;
        state_d     = S_HUNT;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end

    case (state_q)
      S_HUNT: begin
        if (accept && bus.in_data == SYNC) state_d = S_CHAN;
      end
      S_CHAN: begin
        if (accept) begin
          xor_d = bus.in_data;
          if ({24'd0, bus.in_data} >= 32'(N_CHANNELS)) begin
            frame_err_d = 1'b1;
            state_d     = S_HUNT;
          end else begin
            chan_d     = bus.in_data[CH_W-1:0];
            byte_cnt_d = '0;
            state_d    = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (accept) begin
          shadow_d   = {shadow_q[REC_W-9:0], bus.in_data};
          xor_d      = xor_q ^ bus.in_data;
          byte_cnt_d = byte_cnt_q + 6'd1;
          if (byte_cnt_q == LAST_PAYLOAD) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (accept) begin
          if (bus.in_data == xor_q) begin
            wg_data_d    = shadow_q;
            wg_channel_d = chan_q;
            state_d      = S_OUTPUT;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_HUNT;
          end
        end
      end
      S_OUTPUT: begin
        if (bus.wg_ready) begin
          if (wg_data_q[CMDS_LSB + ENVELOPE_RESET_BIT]) env_reset_d[wg_channel_q] = 1'b1;
          state_d = S_HUNT;
        end
      end
      default: state_d = S_HUNT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_HUNT;
      byte_cnt_q   <= '0;
      tmo_q        <= '0;
      xor_q        <= '0;
      shadow_q     <= '0;
      chan_q       <= '0;
      wg_data_q    <= '0;
      wg_channel_q <= '0;
      env_reset_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      tmo_q        <= tmo_d;
      xor_q        <= xor_d;
      shadow_q     <= shadow_d;
      chan_q       <= chan_d;
      wg_data_q    <= wg_data_d;
      wg_channel_q <= wg_channel_d;
      env_reset_q  <= env_reset_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.in_ready   = (state_q != S_OUTPUT);
  assign bus.wg_valid   = (state_q == S_OUTPUT);
  assign bus.wg_data    = wg_data_q;
  assign bus.wg_channel = wg_channel_q;
  assign bus.env_reset  = env_reset_q;
  assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_wavegen_frame_decoder.sv
// Self-checking bench: frame-level reference model compared every cycle, directed
// scenarios with hand-computed field values, then randomized frames and corruptions.
module tb_wavegen_frame_decoder;
  localparam int         N_CH        = 16;
  localparam int         TMO         = 4096;
  localparam int         W           = 376;
  localparam int         ENV_BIT     = 0;
  localparam logic [7:0] SHAPE_SIN   = 8'h01;
  localparam logic [7:0] CMD_ENV_RST = 8'h01;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   errors = 0;

  wavegen_frame_decoder_if #(.N_CHANNELS(N_CH)) bus ();

  wavegen_frame_decoder #(
    .N_CHANNELS        (N_CH),
    .TIMEOUT           (TMO),
    .ENVELOPE_RESET_BIT(ENV_BIT)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (frame-level) ----------------
  logic [7:0]      m_fb[$];
  int              m_idle = 0;
  bit              m_hold = 1'b0;
  logic [W-1:0]    m_data = '0;
  int              m_chan = 0;
  logic [N_CH-1:0] m_env  = '0;
  bit              m_err  = 1'b0;
  logic [N_CH-1:0] n_env;
  bit              n_err;
  logic [7:0]      m_x;

  // monitor results
  int              rec_count  = 0;
  int              err_count  = 0;
  bit              prev_valid = 1'b0;
  logic [W-1:0]    cap_data   = '0;
  int              cap_chan   = 0;
  logic [N_CH-1:0] last_env   = '0;

  always @(posedge clk) begin
    if (!rstn) begin
      m_fb.delete();
      m_idle = 0;
      m_hold = 1'b0;
      m_data = '0;
      m_chan = 0;
      m_env  = '0;
      m_err  = 1'b0;
    end else begin
      n_err = 1'b0;
      n_env = '0;
      if (m_hold) begin
        if (bus.wg_ready) begin
          m_hold = 1'b0;
          if (m_data[W-56+ENV_BIT]) n_env[m_chan] = 1'b1;
        end
      end else if (bus.in_valid) begin
        if (m_fb.size() == 0) begin
          if (bus.in_data == 8'hA5) begin
            m_fb.push_back(bus.in_data);
            m_idle = 0;
          end
        end else begin
          m_fb.push_back(bus.in_data);
          m_idle = 0;
          if (m_fb.size() == 2 && int'(bus.in_data) >= N_CH) begin
            n_err = 1'b1;
            m_fb.delete();
          end else if (m_fb.size() == 50) begin
            m_x = '0;
            for (int i = 1; i <= 48; i++) m_x ^= m_fb[i];
            if (m_x == m_fb[49]) begin
              for (int i = 0; i < 47; i++) m_data[W-1-8*i -: 8] = m_fb[2+i];
              m_chan = int'(m_fb[1]);
              m_hold = 1'b1;
            end else begin
              n_err = 1'b1;
            end
            m_fb.delete();
          end
        end
      end else if (m_fb.size() != 0) begin
        m_idle++;
        if (m_idle == TMO) begin
          n_err = 1'b1;
          m_fb.delete();
          m_idle = 0;
        end
      end
      m_err = n_err;
      m_env = n_env;
    end
    #1;
    check("in_ready",   W'(bus.in_ready),   W'(!m_hold));
    check("wg_valid",   W'(bus.wg_valid),   W'(m_hold));
    check("wg_data",    bus.wg_data,        m_data);
    check("wg_channel", W'(bus.wg_channel), W'(m_chan));
    check("env_reset",  W'(bus.env_reset),  W'(m_env));
    check("frame_err",  W'(bus.frame_err),  W'(m_err));
    if (bus.frame_err) err_count++;
    if (bus.env_reset != '0) last_env = bus.env_reset;
    if (bus.wg_valid && !prev_valid) begin
      rec_count++;
      cap_data = bus.wg_data;
      cap_chan = int'(bus.wg_channel);
    end
    prev_valid = bus.wg_valid;
  end

  // ---------------- stimulus helpers ----------------
  bit          rand_ready = 1'b0;
  logic [7:0]  frm[50];
  logic [15:0] env_rate[8];
  logic [23:0] env_dur[8];

  task automatic tick();
    @(negedge clk);
    if (rand_ready) bus.wg_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      bus.in_valid = 1'b0;
    end
  endtask

  // Leaves in_valid high; the caller's next tick() either replaces or drops the byte.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready) begin
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_byte in_ready never rose actual 0 expected 1");
        return;
      end
      tick();
    end
    @(posedge clk);
  endtask

  function automatic logic [W-1:0] make_rec(input logic [31:0] f, input logic [7:0] v,
                                            input logic [7:0] s, input logic [7:0] c);
    logic [W-1:0] r;
    r = '0;
    r[375:344] = f;
    r[343:336] = v;
    r[335:328] = s;
    r[327:320] = c;
    for (int i = 0; i < 8; i++) r[319-40*i -: 40] = {env_rate[i], env_dur[i]};
    return r;
  endfunction

  task automatic build_frame(input logic [7:0] ch, input logic [W-1:0] rec, input logic [7:0] flip);
    logic [7:0] x;
    frm[0] = 8'hA5;
    frm[1] = ch;
    x      = ch;
    for (int i = 0; i < 47; i++) begin
      frm[2+i] = rec[W-1-8*i -: 8];
      x ^= frm[2+i];
    end
    frm[49] = x ^ flip;
  endtask

  task automatic send_bytes(input int count, input int max_gap);
    for (int i = 0; i < count; i++) begin
      send_byte(frm[i]);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random scenarios ----------------
  logic [W-1:0] rec_ok, rec2, rec_emb, rec_r;
  int           r0, e0, mode;

  initial begin
    rstn         = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.wg_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      env_rate[i] = '0;
      env_dur[i]  = '0;
    end
    idle(3);
    check("rst_in_ready",   W'(bus.in_ready),   W'(1));
    check("rst_wg_valid",   W'(bus.wg_valid),   W'(0));
    check("rst_wg_data",    bus.wg_data,        '0);
    check("rst_env_reset",  W'(bus.env_reset),  W'(0));
    check("rst_frame_err",  W'(bus.frame_err),  W'(0));
    rstn = 1'b1;
    idle(2);

    // Valid frame with hand-computed field values
    env_rate[0] = 16'd100; env_dur[0] = 24'd48000;
    env_rate[6] = 16'd500; env_dur[6] = 24'd288000;
    rec_ok = make_rec(32'd400, 8'd0, SHAPE_SIN, CMD_ENV_RST);
    build_frame(8'd3, rec_ok, 8'h00);
    check("valid_checksum_byte", W'(frm[49]), W'(8'h59));
    r0 = rec_count;
    send_bytes(50, 0);
    idle(4);
    check("valid_records",  W'(rec_count - r0),  W'(1));
    check("valid_chan",     W'(cap_chan),        W'(3));
    check("valid_freq",     W'(cap_data[375:344]), W'(32'd400));
    check("valid_velocity", W'(cap_data[343:336]), W'(8'd0));
    check("valid_shape",    W'(cap_data[335:328]), W'(8'h01));
    check("valid_cmds",     W'(cap_data[327:320]), W'(8'h01));
    check("env0_rate",      W'(cap_data[319:304]), W'(16'd100));
    check("env0_dur",       W'(cap_data[303:280]), W'(24'd48000));
    check("env6_rate",      W'(cap_data[79:64]),   W'(16'd500));
    check("env6_dur",       W'(cap_data[63:40]),   W'(24'd288000));
    check("env3_rate_zero", W'(cap_data[199:184]), W'(16'd0));
    check("env_reset_mask", W'(last_env),          W'(16'h0008));

    // Bad checksum, then a clean frame to another channel
    build_frame(8'd3, rec_ok, 8'h01);
    e0 = err_count; r0 = rec_count;
    send_bytes(50, 0);
    idle(3);
    check("badsum_errs",    W'(err_count - e0), W'(1));
    check("badsum_records", W'(rec_count - r0), W'(0));
    rec2 = make_rec(32'h1234_5678, 8'd99, 8'd2, 8'h00);
    build_frame(8'd5, rec2, 8'h00);
    r0 = rec_count;
    send_bytes(50, 0);
    idle(3);
    check("after_badsum_records", W'(rec_count - r0), W'(1));
    check("after_badsum_chan",    W'(cap_chan),       W'(5));
    check("after_badsum_data",    cap_data,           rec2);

    // Channel out of range: rest of the frame is hunt noise
    build_frame(8'd16, rec_ok, 8'h00);
    e0 = err_count; r0 = rec_count;
    send_bytes(50, 0);
    idle(3);
    check("badchan_errs",    W'(err_count - e0), W'(1));
    check("badchan_records", W'(rec_count - r0), W'(0));

    // Backpressure for 20 cycles
    build_frame(8'd7, rec_ok, 8'h00);
    r0 = rec_count;
    bus.wg_ready = 1'b0;
    send_bytes(50, 0);
    idle(20);
    check("bp_valid_held", W'(bus.wg_valid), W'(1));
    check("bp_in_ready",   W'(bus.in_ready), W'(0));
    check("bp_data",       bus.wg_data,      rec_ok);
    bus.wg_ready = 1'b1;
    idle(3);
    check("bp_released", W'(bus.wg_valid),   W'(0));
    check("bp_records",  W'(rec_count - r0), W'(1));

    // Timeout after payload byte 10, then a clean frame
    build_frame(8'd9, rec_ok, 8'h00);
    e0 = err_count; r0 = rec_count;
    send_bytes(13, 0);
    idle(TMO + 3);
    check("timeout_errs", W'(err_count - e0), W'(1));
    send_bytes(50, 0);
    idle(3);
    check("timeout_records", W'(rec_count - r0), W'(1));
    check("timeout_chan",    W'(cap_chan),       W'(9));

    // Reset at payload byte 30
    build_frame(8'd2, rec_ok, 8'h00);
    e0 = err_count;
    send_bytes(33, 0);
    idle(1);
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    idle(2);
    check("reset_no_err",    W'(err_count - e0), W'(0));
    check("reset_valid",     W'(bus.wg_valid),   W'(0));
    check("reset_data",      bus.wg_data,        '0);
    check("reset_chan",      W'(bus.wg_channel), W'(0));
    check("reset_in_ready",  W'(bus.in_ready),   W'(1));

    // Leading garbage and 0xA5 payload bytes
    rec_emb = make_rec(32'hA5A5_0001, 8'hA5, 8'hA5, 8'h00);
    build_frame(8'd4, rec_emb, 8'h00);
    e0 = err_count; r0 = rec_count;
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
    send_bytes(50, 0);
    idle(3);
    check("emb_no_err",  W'(err_count - e0),  W'(0));
    check("emb_records", W'(rec_count - r0),  W'(1));
    check("emb_velocity", W'(cap_data[343:336]), W'(8'hA5));
    check("emb_data",    cap_data,            rec_emb);

    // Randomized frames, corruptions, gaps and backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 47; i++) rec_r[W-1-8*i -: 8] = 8'($urandom);
      mode = $urandom_range(0, 9);
      if (mode <= 5)      build_frame(8'($urandom_range(0, N_CH-1)), rec_r, 8'h00);
      else if (mode <= 7) build_frame(8'($urandom_range(0, N_CH-1)), rec_r, 8'($urandom_range(1, 255)));
      else if (mode == 8) build_frame(8'($urandom_range(N_CH, 255)), rec_r, 8'h00);
      else begin
        repeat ($urandom_range(1, 4)) send_byte(8'($urandom_range(0, 8'hA4)));
        build_frame(8'($urandom_range(0, N_CH-1)), rec_r, 8'h00);
      end
      send_bytes(50, $urandom_range(0, 2));
    end
    rand_ready = 1'b0;
    bus.wg_ready = 1'b1;
    idle(TMO + 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
